// File: rtl/multicycle_alu.sv
// multicycle_alu: base integer ALU plus an optional iterative multiply/divide
// unit, compiled in when the MULDIV_EN macro is defined; one operation in flight.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             m_ext,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: start is taken only on an edge where state is IDLE (busy=0);
  // valid is a single-cycle pulse in DONE with no back-pressure, and result/zero
  // hold their value until the next valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state;

  logic             quick;
  logic [WIDTH-1:0] quick_result;

  function automatic logic [WIDTH-1:0] base_op(input logic [3:0]       ctl,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (ctl)
      4'b0000: base_op = a + b;
      4'b1000: base_op = a - b;
      4'b0001: base_op = a << sh;
      4'b0010: base_op = WIDTH'($signed(a) < $signed(b));
      4'b0011: base_op = WIDTH'(a < b);
      4'b0100: base_op = a ^ b;
      4'b0101: base_op = a >> sh;
      4'b1101: base_op = $signed(a) >>> sh;
      4'b0110: base_op = a | b;
      4'b0111: base_op = a & b;
      default: base_op = '0;
    endcase
  endfunction

`ifdef MULDIV_EN
  // hi/lo form the product {hi,lo} when multiplying, and remainder/quotient
  // when dividing; opb is the multiplicand or divisor magnitude.
  logic [WIDTH-1:0] hi, lo, opb;
  logic [2:0]       op_ctl;
  logic             neg_main, neg_rem;
  logic [SHW-1:0]   cnt;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_by_zero, signed_ovf;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] hi_next, lo_next, fix_result, prod_hi_neg;

  always_comb begin
    a_signed    = alu_control[2] ? !alu_control[0]
                                 : (alu_control[1:0] == 2'b01 || alu_control[1:0] == 2'b10);
    b_signed    = alu_control[2] ? !alu_control[0] : (alu_control[1:0] == 2'b01);
    a_neg       = a_signed && operand1[WIDTH-1];
    b_neg       = b_signed && operand2[WIDTH-1];
    mag1        = a_neg ? -operand1 : operand1;
    mag2        = b_neg ? -operand2 : operand2;
    div_by_zero = alu_control[2] && (operand2 == '0);
    signed_ovf  = alu_control[2] && !alu_control[0] &&
                  (operand1 == MOST_NEG) && (operand2 == '1);
  end

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    if (!op_ctl[2]) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      hi_next = div_trial[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = div_shift[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // High word of -{hi,lo}: a carry reaches hi only when lo is all zeros.
  always_comb begin
    prod_hi_neg = ~hi + WIDTH'(lo == '0);
    case (op_ctl)
      3'b000:                 fix_result = lo;
      3'b001, 3'b010, 3'b011: fix_result = neg_main ? prod_hi_neg : hi;
      3'b100, 3'b101:         fix_result = neg_main ? -lo : lo;
      default:                fix_result = neg_rem ? -hi : hi;
    endcase
  end
`endif

  // Ops that finish straight from IDLE, and their result.
  always_comb begin
    quick        = 1'b1;
    quick_result = base_op(alu_control, operand1, operand2);
    if (m_ext) begin
`ifdef MULDIV_EN
      quick = div_by_zero || signed_ovf;
      if (div_by_zero) begin
        quick_result = alu_control[1] ? operand1 : '1;
      end else if (signed_ovf) begin
        quick_result = alu_control[1] ? '0 : operand1;
      end else begin
        quick_result = '0;
      end
`else
      quick_result = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
`ifdef MULDIV_EN
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      op_ctl   <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (abort && (state == CALC || state == FIX)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (quick) begin
                state  <= DONE;
                valid  <= 1'b1;
                result <= quick_result;
                zero   <= (quick_result == '0);
              end
`ifdef MULDIV_EN
              else begin
                state    <= CALC;
                op_ctl   <= alu_control[2:0];
                hi       <= '0;
                lo       <= mag1;
                opb      <= mag2;
                neg_main <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                cnt      <= '0;
              end
`endif
            end
          end
`ifdef MULDIV_EN
          CALC: begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + SHW'(1);
            if (cnt == '1) begin
              state <= FIX;
            end
          end
          FIX: begin
            state  <= DONE;
            valid  <= 1'b1;
            result <= fix_result;
            zero   <= (fix_result == '0);
          end
`endif
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: random ops scored against a behavioural model, plus directed
// corner cases (short-circuit divides, abort, start collisions, async reset).
module tb_multicycle_alu;

  localparam int W        = 32;
  localparam int LAT_ITER = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         m_ext = 1'b0;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         busy, valid, zero;
  logic [W-1:0] result;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r;
  logic [W-1:0] last_result = '0;
  int           checks = 0;
  int           failures = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .m_ext       (m_ext),
    .alu_control (alu_control),
    .operand1    (operand1),
    .operand2    (operand2),
    .busy        (busy),
    .valid       (valid),
    .result      (result),
    .zero        (zero)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model(input logic m, input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r, output int lat);
`ifdef MULDIV_EN
    longint       sa, sb, sp;
    logic [63:0]  up;
`endif
    lat = 1;
    r   = '0;
    if (!m) begin
      case (ctl)
        4'b0000: r = a + b;
        4'b1000: r = a - b;
        4'b0001: r = a << b[4:0];
        4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'b0011: r = (a < b) ? 32'd1 : 32'd0;
        4'b0100: r = a ^ b;
        4'b0101: r = a >> b[4:0];
        4'b1101: r = $signed(a) >>> b[4:0];
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        default: r = '0;
      endcase
    end
`ifdef MULDIV_EN
    else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lat = LAT_ITER;
      case (ctl[2:0])
        3'd0: r = a * b;
        3'd1: begin sp = sa * sb; r = sp[63:32]; end
        3'd2: begin sp = sa * longint'(b); r = sp[63:32]; end
        3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
        default: begin
          if (b == '0) begin
            lat = 1;
            r   = ctl[1] ? a : '1;
          end else if (!ctl[0] && a == 32'h8000_0000 && b == '1) begin
            lat = 1;
            r   = ctl[1] ? '0 : a;
          end else begin
            case (ctl[1:0])
              2'b00:   r = $signed(a) / $signed(b);
              2'b01:   r = a / b;
              2'b10:   r = $signed(a) % $signed(b);
              default: r = a % b;
            endcase
          end
        end
      endcase
    end
`endif
  endtask

  // ---------------- scoreboard: every valid must match the oldest expectation ----------------
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", valid, 1'b0);
      end else begin
        exp_r = exp_q.pop_front();
        check_eq("result", result, exp_r);
        check_eq("zero", zero, exp_r == '0);
        last_result = exp_r;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7fff_ffff;
      5:       return 32'($urandom_range(0, 16));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge valid is seen.
  task automatic send(input logic m, input logic [3:0] ctl, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    logic [W-1:0] e;
    int           exp_lat;
    int           lat;
    model(m, ctl, a, b, e, exp_lat);
    m_ext = m; alu_control = ctl; operand1 = a; operand2 = b; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    m_ext = 1'($urandom); alu_control = 4'($urandom);
    operand1 = $urandom;  operand2 = $urandom;
    lat = 1;
    while (!valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, exp_lat);
  endtask

  task automatic run_op(input logic m, input logic [3:0] ctl, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    @(negedge clk);
    send(m, ctl, a, b);
  endtask

  // ---------------- main sequence ----------------
  initial begin
`ifdef MULDIV_EN
    logic [W-1:0] e;
    int           el, lat;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_result", result, '0);
    check_eq("rst_zero", zero, 1'b1);

    // Release and start in the same cycle: accepted on the first rising edge.
    rst_n = 1'b1;
    send(1'b0, 4'b1000, 32'd5, 32'd7);
    run_op(1'b0, 4'b1101, 32'h8000_0000, 32'd4);
    run_op(1'b1, 4'b0001, '1, 32'd2);
    run_op(1'b1, 4'b0011, '1, 32'd2);
    run_op(1'b1, 4'b0100, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 4'b0110, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 4'b0101, 32'd9, 32'd0);
    run_op(1'b1, 4'b0110, 32'h8000_0000, '1);
    run_op(1'b1, 4'b1100, 32'h8000_0000, '1);

    for (int i = 0; i < 80; i++) begin
      run_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
    end

    // abort held high with start in IDLE, and through DONE, changes nothing
    @(negedge clk);
    abort = 1'b1;
    send(1'b0, 4'b0000, 32'd40, 32'd2);
    abort = 1'b0;

    // start during the valid cycle is dropped
    run_op(1'b0, 4'b0110, 32'h0f0, 32'h00f);
    start = 1'b1; m_ext = 1'b0; alu_control = 4'b0000; operand1 = 32'd1; operand2 = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("start_on_valid_ignored", busy, 1'b0);
    end

`ifdef MULDIV_EN
    // abort in cycle 10 of a DIVU
    m_ext = 1'b1; alu_control = 4'b0101; operand1 = 32'd1000; operand2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_result_held", result, last_result);
    check_eq("abort_zero_held", zero, last_result == '0);
    repeat (LAT_ITER) @(negedge clk);

    // start held high while busy yields exactly one valid
    model(1'b1, 4'b0000, 32'd123, 32'd456, e, el);
    m_ext = 1'b1; alu_control = 4'b0000; operand1 = 32'd123; operand2 = 32'd456; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    alu_control = 4'b0001; operand1 = '1;
    lat = 1;
    while (!valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_eq("busy_start_latency", lat, el);
    repeat (3) begin
      @(negedge clk);
      check_eq("busy_start_no_second", busy, 1'b0);
    end

    // asynchronous reset in cycle 5 of a MUL
    m_ext = 1'b1; alu_control = 4'b0000; operand1 = 32'h1234; operand2 = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
`else
    // asynchronous reset while a completed op's valid is still pending
    m_ext = 1'b0; alu_control = 4'b0110; operand1 = 32'h1234; operand2 = 32'h5678; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_valid", valid, 1'b0);
    check_eq("async_rst_result", result, '0);
    check_eq("async_rst_zero", zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT_ITER + 2) @(negedge clk);
    check_eq("post_reset_idle", busy, 1'b0);
    check_eq("post_reset_result", result, '0);

    run_op(1'b0, 4'b0000, 32'hFFFF_FFFF, 32'd1);
    run_op(1'b1, 4'b0000, 32'd3, 32'd5);

    @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32; datapath width; power of two, 8..64.
REQ-002 SHALL have localparam SHW = log2(WIDTH); shift-amount bits taken from operand2[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancels an in-flight operation.
REQ-007 SHALL have port m_ext  input  1  1 = multiply/divide op selected by alu_control[2:0].
REQ-008 SHALL have port alu_control  input  4  op code.
REQ-009 SHALL have port operand1  input  WIDTH  first operand (rs1).
REQ-010 SHALL have port operand2  input  WIDTH  second operand (rs2/imm).
REQ-011 SHALL have port busy  output  1  high while not IDLE.
REQ-012 SHALL have port valid  output  1  one-cycle pulse, result ready.
REQ-013 SHALL have port result  output  WIDTH  registered result, held until next valid.
REQ-014 SHALL have port zero  output  1  registered, (result == 0), updated with result.

Function
REQ-015 SHALL latch m_ext, alu_control, operand1, operand2 on the edge where start=1 in IDLE; later input changes SHALL not affect the operation.
REQ-016 SHALL implement base ops (m_ext=0): 0000 add; 1000 sub; 0001 sll; 0010 slt signed; 0011 sltu; 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and; other codes -> 0.
REQ-017 SHALL implement M ops (m_ext=1, alu_control[3] ignored) per alu_control[2:0]: 000 MUL low; 001 MULH s*s high; 010 MULHSU s*u high; 011 MULHU u*u high; 100 DIV; 101 DIVU; 110 REM; 111 REMU.
REQ-018 SHALL have states IDLE, CALC, FIX, DONE.
REQ-019 SHALL transition IDLE->DONE on start with base op, DIV/REM divide-by-zero, or signed overflow; IDLE->CALC on start with any other M op.
REQ-020 SHALL, in CALC, run iterative shift-add multiply or restoring divide, one bit per cycle, on magnitudes, exactly WIDTH cycles, then go to FIX.
REQ-021 SHALL, in FIX, apply sign correction (negate product/quotient/remainder as required; remainder takes dividend sign), then go to DONE.
REQ-022 SHALL, in DONE, update result and zero, assert valid for exactly that cycle, and return to IDLE.
REQ-023 Latency from start edge to valid cycle SHALL be 1 cycle for base/short-circuit ops and WIDTH+2 cycles for iterative ops (34 at WIDTH=32).
REQ-024 Divide by zero SHALL give quotient all-ones (DIV/DIVU) and remainder = operand1 (REM/REMU).
REQ-025 Signed overflow (operand1 = most negative, operand2 = -1) SHALL give DIV = operand1, REM = 0.
REQ-026 start while busy SHALL be ignored, with no queuing.
REQ-027 start in the same cycle valid is high SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-028 abort in CALC or FIX SHALL force IDLE on the next edge, with no valid and result/zero unchanged; abort in IDLE or DONE SHALL have no effect.
REQ-029 abort and start together in IDLE SHALL accept start.
REQ-030 Add/sub/mul SHALL wrap modulo 2^WIDTH with no overflow flag.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, busy=0, valid=0, result=0, zero=1, and clear internal counters and accumulators.
REQ-032 Reset asserted mid-operation SHALL discard the operation, with no valid after release.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-034 Macro MULDIV_EN SHALL gate the multiply/divide datapath.
REQ-035 With MULDIV_EN defined, M ops SHALL behave per REQ-017..REQ-025.
REQ-036 Without MULDIV_EN, the CALC and FIX logic SHALL be absent, every m_ext=1 op SHALL complete in 1 cycle with result=0 and zero=1, and base-op behaviour SHALL be unchanged.

Verification
REQ-037 Scenario: base ops, start with sub, op1=5, op2=7 -> valid one cycle later, result=0xFFFFFFFE, zero=0; sra 0x80000000 by 4 -> 0xF8000000.
REQ-038 Scenario: MULH -> start, m_ext=1, ctl=001, op1=0xFFFFFFFF (-1), op2=2 -> valid at cycle 34, result=0xFFFFFFFF; MULHU with the same operands -> 0x00000001.
REQ-039 Scenario: DIV -7/2 -> quotient 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; both at cycle 34.
REQ-040 Scenario: divide by zero, DIVU 9/0 -> 0xFFFFFFFF at cycle 1; REM 0x80000000 by -1 -> 0, zero=1, at cycle 1.
REQ-041 Scenario: abort at cycle 10 of a DIVU -> busy drops next cycle, no valid, result keeps prior value; start while busy produces no second valid.
REQ-042 Scenario: rst_n low at cycle 5 of a MUL -> busy=0, result=0, zero=1 immediately (asynchronously), no valid after release; build without MULDIV_EN -> MUL returns 0 in 1 cycle.
